tile_run_ctrl: RTL and testbench
================================

Name: tile_run_ctrl

Overview:
Memory-mapped run controller that sequences one compute tile through boot, execution and end-of-computation (EOC). A host or debug master programs the boot address and watchdog limit, then starts the run. The controller drives the core fetch enable and captures the exit code the tile software writes at EOC. It raises a done/timeout indication and a one-cycle interrupt, replacing ad-hoc polling of EOC.

Parameters:
BOOT_ADDR_RST, 32'h0000_0000, reset value of BOOT_ADDR register
CNT_W, 32, width of watchdog cycle counter and TIMEOUT register (1..32)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
reg_req_i  in  1  register request
reg_we_i  in  1  1=write, 0=read
reg_addr_i  in  3  word index: 0 BOOT_ADDR, 1 CTRL, 2 STATUS, 3 EOC, 4 TIMEOUT, 5 CYCLES
reg_wdata_i  in  32  write data
reg_gnt_o  out  1  grant, equals reg_req_i (combinational)
reg_rvalid_o  out  1  response valid, one cycle after each granted request (read or write)
reg_rdata_o  out  32  read data, valid with reg_rvalid_o; 0 for writes
fetch_en_o  out  1  core fetch enable
boot_addr_o  out  32  boot address to core
busy_o  out  1  high in BOOT or RUN
eoc_o  out  1  high in DONE
timeout_o  out  1  high in TMO
exit_code_o  out  32  captured exit code
irq_o  out  1  one-cycle pulse on entry to DONE or TMO

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0 except boot_addr_o=BOOT_ADDR_RST; TIMEOUT=0; CYCLES=0; pending response cleared.
- Registers:
  - BOOT_ADDR: RW. Writes ignored while busy_o=1.
  - CTRL: write-only; reads return 0. bit0 START, bit1 ABORT.
  - STATUS: RO = {27'b0, state[2:0], timeout_o, eoc_o}. Encoding: IDLE=0, BOOT=1, RUN=2, DONE=3, TMO=4.
  - EOC: write captures wdata into exit_code_o (accepted only in RUN); reads return exit_code_o.
  - TIMEOUT: RW, CNT_W bits, zero-extended on read; 0 disables the watchdog; writes ignored while busy_o=1.
  - CYCLES: RO, cycles spent in RUN for the current/last run; saturates at all-ones.
  - Unmapped index (6,7): read 0, write ignored.
- FSM:
  - IDLE: START -> BOOT.
  - BOOT: exactly 1 cycle. Clear CYCLES, exit_code_o, eoc_o and timeout_o; boot_addr_o stable; fetch_en_o=0. Then -> RUN.
  - RUN: fetch_en_o=1; CYCLES increments each cycle.
    - EOC write -> DONE.
    - Else TIMEOUT!=0 and CYCLES==TIMEOUT-1 at a clock edge -> TMO. The first cycle in RUN sees CYCLES=0, so a limit of N gives exactly N RUN cycles.
    - ABORT -> IDLE (fetch_en_o=0 next cycle, no irq).
  - DONE / TMO: fetch_en_o=0; status flags held. START -> BOOT (restart); ABORT -> IDLE (clears flags).
- Simultaneous events (same write cannot carry two targets; resolve across CTRL bits and state events):
  - START and ABORT both set -> ABORT wins.
  - In the RUN cycle where the watchdog expires and an EOC write is granted -> EOC wins (DONE, exit code captured).
  - START in BOOT or RUN -> ignored.
  - EOC write outside RUN -> ignored; exit_code_o unchanged.
- irq_o: registered, high for exactly the first cycle in which eoc_o or timeout_o is high.
- Registered state outputs (fetch_en_o, busy_o, eoc_o, timeout_o) change on the edge that enters the new state.
- Reset mid-run: fetch_en_o drops asynchronously with rst_ni; no irq is generated.
- Back-to-back register requests every cycle are supported. Each gets its rvalid the following cycle.

Test Plan:
- Reset, read BOOT_ADDR/STATUS -> BOOT_ADDR_RST and 0; all outputs 0; rvalid 1 cycle after each req.
- Write BOOT_ADDR=0xCC00_0080, START -> fetch_en_o rises 2 cycles after START grant, boot_addr_o=0xCC00_0080. EOC write 0x0 after 100 RUN cycles -> eoc_o=1, irq_o single pulse, exit_code_o=0, CYCLES=100.
- TIMEOUT=50, START, no EOC -> timeout_o=1 and fetch_en_o=0 after exactly 50 RUN cycles; STATUS=0x12; one irq pulse.
- TIMEOUT=50 with EOC write 0xDEAD in the 50th RUN cycle -> DONE, exit_code_o=0xDEAD, timeout_o=0.
- ABORT during RUN -> IDLE, fetch_en_o low next cycle, no irq. BOOT_ADDR write during RUN ignored (readback unchanged). START+ABORT together -> stays IDLE.
- rst_ni asserted mid-RUN -> fetch_en_o=0 immediately. After release, STATUS=0 and the EOC register reads 0. Restart from DONE via START -> flags cleared in BOOT.

Source files
------------

// File: rtl/tile_run_ctrl.sv
// Run controller for one compute tile: register-mapped boot/run/EOC sequencing
// with a watchdog, exit-code capture and a single-cycle completion interrupt.
module tile_run_ctrl #(
  parameter logic [31:0] BOOT_ADDR_RST = 32'h0000_0000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        reg_req_i,
  input  logic        reg_we_i,
  input  logic [2:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic        reg_gnt_o,
  output logic        reg_rvalid_o,
  output logic [31:0] reg_rdata_o,
  output logic        fetch_en_o,
  output logic [31:0] boot_addr_o,
  output logic        busy_o,
  output logic        eoc_o,
  output logic        timeout_o,
  output logic [31:0] exit_code_o,
  output logic        irq_o
);

  localparam int unsigned DW = 32;
  localparam logic [2:0] A_BOOT    = 3'd0;
  localparam logic [2:0] A_CTRL    = 3'd1;
  localparam logic [2:0] A_STATUS  = 3'd2;
  localparam logic [2:0] A_EOC     = 3'd3;
  localparam logic [2:0] A_TIMEOUT = 3'd4;
  localparam logic [2:0] A_CYCLES  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BOOT = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_TMO  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    boot_addr_q, boot_addr_d;
  logic [DW-1:0]    exit_code_q, exit_code_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             fetch_en_q, fetch_en_d;
  logic             busy_q, busy_d;
  logic             eoc_q, eoc_d;
  logic             tmo_q, tmo_d;
  logic             irq_q, irq_d;
  logic             rvalid_q, rvalid_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic wr_c, rd_c, start_c, abort_c, eoc_wr_c, wd_hit_c;

  // Request decode and watchdog compare
  always_comb begin
    wr_c     = reg_req_i & reg_we_i;
    rd_c     = reg_req_i & ~reg_we_i;
    start_c  = wr_c && (reg_addr_i == A_CTRL) && reg_wdata_i[0];
    abort_c  = wr_c && (reg_addr_i == A_CTRL) && reg_wdata_i[1];
    eoc_wr_c = wr_c && (reg_addr_i == A_EOC) && (state_q == ST_RUN);
    wd_hit_c = (state_q == ST_RUN) && (timeout_q != '0) &&
               (cycles_q == timeout_q - CNT_W'(1));
  end

  // Next state, register file and registered outputs
  always_comb begin
    state_d     = state_q;
    boot_addr_d = boot_addr_q;
    exit_code_d = exit_code_q;
    timeout_d   = timeout_q;
    cycles_d    = cycles_q;
    rvalid_d    = reg_req_i;
    rdata_d     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (abort_c)      state_d = ST_IDLE;
        else if (start_c) state_d = ST_BOOT;
      end
      ST_BOOT: begin
        state_d = abort_c ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (eoc_wr_c)      state_d = ST_DONE;
        else if (wd_hit_c) state_d = ST_TMO;
        else if (abort_c)  state_d = ST_IDLE;
      end
      ST_DONE, ST_TMO: begin
        if (abort_c)      state_d = ST_IDLE;
        else if (start_c) state_d = ST_BOOT;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q == ST_RUN && cycles_q != {CNT_W{1'b1}}) cycles_d = cycles_q + CNT_W'(1);

    if (eoc_wr_c) exit_code_d = reg_wdata_i;

    // Entering BOOT starts a fresh run record
    if (state_d == ST_BOOT && state_q != ST_BOOT) begin
      cycles_d    = '0;
      exit_code_d = '0;
    end

    if (wr_c && !busy_q) begin
      if (reg_addr_i == A_BOOT)    boot_addr_d = reg_wdata_i;
      if (reg_addr_i == A_TIMEOUT) timeout_d   = CNT_W'(reg_wdata_i);
    end

    if (rd_c) begin
      unique case (reg_addr_i)
        A_BOOT:    rdata_d = boot_addr_q;
        A_STATUS:  rdata_d = {27'd0, 3'(state_q), tmo_q, eoc_q};
        A_EOC:     rdata_d = exit_code_q;
        A_TIMEOUT: rdata_d = DW'(timeout_q);
        A_CYCLES:  rdata_d = DW'(cycles_q);
        default:   rdata_d = '0;
      endcase
    end

    fetch_en_d = (state_d == ST_RUN);
    busy_d     = (state_d == ST_BOOT) || (state_d == ST_RUN);
    eoc_d      = (state_d == ST_DONE);
    tmo_d      = (state_d == ST_TMO);
    irq_d      = (state_d != state_q) && ((state_d == ST_DONE) || (state_d == ST_TMO));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      boot_addr_q <= BOOT_ADDR_RST;
      exit_code_q <= '0;
      timeout_q   <= '0;
      cycles_q    <= '0;
      fetch_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      eoc_q       <= 1'b0;
      tmo_q       <= 1'b0;
      irq_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      boot_addr_q <= boot_addr_d;
      exit_code_q <= exit_code_d;
      timeout_q   <= timeout_d;
      cycles_q    <= cycles_d;
      fetch_en_q  <= fetch_en_d;
      busy_q      <= busy_d;
      eoc_q       <= eoc_d;
      tmo_q       <= tmo_d;
      irq_q       <= irq_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign reg_gnt_o    = reg_req_i;
  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;
  assign fetch_en_o   = fetch_en_q;
  assign boot_addr_o  = boot_addr_q;
  assign busy_o       = busy_q;
  assign eoc_o        = eoc_q;
  assign timeout_o    = tmo_q;
  assign exit_code_o  = exit_code_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_tile_run_ctrl.sv
// Bench for tile_run_ctrl: directed register traffic with a queue-based
// response scoreboard plus direct checks of the run-state outputs.
module tb_tile_run_ctrl;

  localparam logic [31:0] RST_BA = 32'h1A00_0000;
  localparam logic [2:0] A_BOOT = 3'd0, A_CTRL = 3'd1, A_STATUS = 3'd2;
  localparam logic [2:0] A_EOC = 3'd3, A_TMO = 3'd4, A_CYC = 3'd5;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        reg_req_i, reg_we_i;
  logic [2:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic        reg_gnt_o, reg_rvalid_o;
  logic [31:0] reg_rdata_o;
  logic        fetch_en_o, busy_o, eoc_o, timeout_o, irq_o;
  logic [31:0] boot_addr_o, exit_code_o;

  int n_cmp = 0;
  int n_err = 0;
  int irq_cnt = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];

  tile_run_ctrl #(.BOOT_ADDR_RST(RST_BA), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .reg_req_i(reg_req_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_gnt_o(reg_gnt_o), .reg_rvalid_o(reg_rvalid_o),
    .reg_rdata_o(reg_rdata_o), .fetch_en_o(fetch_en_o), .boot_addr_o(boot_addr_o),
    .busy_o(busy_o), .eoc_o(eoc_o), .timeout_o(timeout_o),
    .exit_code_o(exit_code_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // {fetch_en, busy, eoc, timeout, irq}
  task automatic chk_out(input string name, input logic [4:0] exp);
    check(name, 32'({fetch_en_o, busy_o, eoc_o, timeout_o, irq_o}), 32'(exp));
  endtask

  // Response monitor: every rvalid must match the oldest queued expectation
  always @(negedge clk_i) begin
    if (irq_o) irq_cnt++;
    if (reg_rvalid_o) begin
      if (exp_q.size() == 0) check("unexpected_rvalid", 32'h1, 32'h0);
      else check(nm_q.pop_front(), reg_rdata_o, exp_q.pop_front());
    end
  end

  task automatic acc(input logic we, input logic [2:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input string nm);
    exp_q.push_back(we ? 32'h0 : exp);
    nm_q.push_back(nm);
    reg_req_i = 1'b1; reg_we_i = we; reg_addr_i = a; reg_wdata_i = d;
    #1 check({nm, "_gnt"}, 32'(reg_gnt_o), 32'h1);
    @(posedge clk_i); #1;
    reg_req_i = 1'b0; reg_we_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 32'h1, 32'h0);
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_ni = 1'b0; reg_req_i = 1'b0; reg_we_i = 1'b0;
    reg_addr_i = '0; reg_wdata_i = '0;
    repeat (3) @(posedge clk_i); #1;
    chk_out("reset_outs", 5'b00000);
    check("reset_boot_addr_o", boot_addr_o, RST_BA);
    check("reset_exit_code_o", exit_code_o, 32'h0);
    rst_ni = 1'b1;
    idle(1);

    // Reset register contents
    acc(0, A_BOOT,   0, RST_BA, "rd_boot_rst");
    acc(0, A_STATUS, 0, 32'h0,  "rd_status_rst");
    acc(0, A_CYC,    0, 32'h0,  "rd_cycles_rst");
    acc(0, A_TMO,    0, 32'h0,  "rd_timeout_rst");
    acc(0, A_EOC,    0, 32'h0,  "rd_eoc_rst");
    acc(0, A_CTRL,   0, 32'h0,  "rd_ctrl");
    acc(0, 3'd6,     0, 32'h0,  "rd_unmapped");

    // Boot and complete via EOC in the 100th RUN cycle
    acc(1, A_BOOT, 32'hCC00_0080, 0, "wr_boot");
    check("boot_addr_o", boot_addr_o, 32'hCC00_0080);
    acc(1, A_CTRL, 32'h1, 0, "wr_start1");
    chk_out("in_boot1", 5'b01000);
    idle(1);
    chk_out("run_first", 5'b11000);
    idle(99);
    acc(1, A_EOC, 32'h0, 0, "wr_eoc0");
    chk_out("done_entry", 5'b00101);
    check("exit_code_0", exit_code_o, 32'h0);
    idle(1);
    chk_out("done_hold", 5'b00100);
    check("irq_cnt_done", 32'(irq_cnt), 32'd1);
    acc(0, A_CYC,    0, 32'd100, "rd_cycles_100");
    acc(0, A_STATUS, 0, 32'h0D,  "rd_status_done");

    // Watchdog expiry after 50 RUN cycles
    acc(1, A_TMO, 32'd50, 0, "wr_timeout50");
    acc(0, A_TMO, 0, 32'd50, "rd_timeout50");
    acc(1, A_CTRL, 32'h1, 0, "wr_start2");
    chk_out("restart_clears_eoc", 5'b01000);
    acc(0, A_CYC, 0, 32'h0, "rd_cycles_in_boot");
    idle(49);
    chk_out("run_cycle50", 5'b11000);
    idle(1);
    chk_out("tmo_entry", 5'b00011);
    idle(1);
    chk_out("tmo_hold", 5'b00010);
    check("irq_cnt_tmo", 32'(irq_cnt), 32'd2);
    acc(0, A_STATUS, 0, 32'h12,  "rd_status_tmo");
    acc(0, A_CYC,    0, 32'd50,  "rd_cycles_50");

    // EOC write in the same cycle the watchdog expires: EOC wins
    acc(1, A_CTRL, 32'h1, 0, "wr_start3");
    chk_out("restart_clears_tmo", 5'b01000);
    idle(1);
    idle(49);
    acc(1, A_EOC, 32'h0000_DEAD, 0, "wr_eoc_dead");
    chk_out("eoc_beats_wd", 5'b00101);
    check("exit_code_dead", exit_code_o, 32'h0000_DEAD);
    acc(0, A_CYC,    0, 32'd50,         "rd_cycles_tie");
    acc(0, A_EOC,    0, 32'h0000_DEAD,  "rd_eoc_dead");
    acc(0, A_STATUS, 0, 32'h0D,         "rd_status_tie");
    check("irq_cnt_tie", 32'(irq_cnt), 32'd3);

    // Abort in RUN, writes ignored while busy, START+ABORT together
    acc(1, A_TMO, 32'h0, 0, "wr_timeout0");
    acc(1, A_CTRL, 32'h1, 0, "wr_start4");
    check("exit_code_cleared", exit_code_o, 32'h0);
    idle(1);
    acc(1, A_BOOT, 32'h1234_5678, 0, "wr_boot_busy");
    acc(1, A_TMO,  32'd7,         0, "wr_timeout_busy");
    acc(0, A_BOOT, 0, 32'hCC00_0080, "rd_boot_unchanged");
    acc(0, A_TMO,  0, 32'h0,         "rd_timeout_unchanged");
    acc(1, A_CTRL, 32'h1, 0, "wr_start_in_run");
    chk_out("start_ignored_run", 5'b11000);
    acc(1, A_CTRL, 32'h2, 0, "wr_abort");
    chk_out("abort_idle", 5'b00000);
    idle(1);
    check("irq_cnt_abort", 32'(irq_cnt), 32'd3);
    acc(0, A_STATUS, 0, 32'h0, "rd_status_abort");
    acc(1, A_EOC, 32'h55, 0, "wr_eoc_idle");
    acc(0, A_EOC, 0, 32'h0, "rd_eoc_idle");
    check("exit_code_idle", exit_code_o, 32'h0);
    acc(1, A_CTRL, 32'h3, 0, "wr_start_abort");
    chk_out("start_abort_idle", 5'b00000);
    acc(0, A_STATUS, 0, 32'h0, "rd_status_sa");
    acc(1, 3'd7, 32'hFFFF_FFFF, 0, "wr_unmapped");
    acc(0, A_BOOT, 0, 32'hCC00_0080, "rd_boot_after_unmapped");

    // Asynchronous reset in the middle of a run
    acc(1, A_CTRL, 32'h1, 0, "wr_start5");
    idle(6);
    chk_out("run_pre_rst", 5'b11000);
    #2 rst_ni = 1'b0;
    #1 chk_out("async_rst", 5'b00000);
    check("async_rst_boot_addr", boot_addr_o, RST_BA);
    repeat (2) @(posedge clk_i); #1;
    rst_ni = 1'b1;
    idle(1);
    acc(0, A_STATUS, 0, 32'h0,  "rd_status_post_rst");
    acc(0, A_EOC,    0, 32'h0,  "rd_eoc_post_rst");
    acc(0, A_CYC,    0, 32'h0,  "rd_cycles_post_rst");
    acc(0, A_BOOT,   0, RST_BA, "rd_boot_post_rst");
    idle(2);
    check("irq_cnt_final", 32'(irq_cnt), 32'd3);
    check("responses_outstanding", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
